// File: rtl/cmp_share_if.sv
// Request/response bundle between the execute-stage requesters (ALU compare
// path A, branch unit B) and the shared comparator controller.
interface cmp_share_if #(
    parameter int TAG_W = 5
);
    logic             a_req_valid;
    logic             a_req_ready;
    logic [2:0]       a_func3;
    logic [31:0]      a_rs1_data;
    logic [31:0]      a_rs2_data;
    logic [TAG_W-1:0] a_tag;
    logic             a_resp_valid;
    logic             a_resp_ready;
    logic [31:0]      a_resp_out;
    logic [TAG_W-1:0] a_resp_tag;
    logic             a_resp_illegal;

    logic             b_req_valid;
    logic             b_req_ready;
    logic [2:0]       b_func3;
    logic [31:0]      b_rs1_data;
    logic [31:0]      b_rs2_data;
    logic [TAG_W-1:0] b_tag;
    logic             b_resp_valid;
    logic             b_resp_ready;
    logic             b_resp_taken;
    logic [TAG_W-1:0] b_resp_tag;
    logic             b_resp_illegal;

    modport master (
        output a_req_valid, a_func3, a_rs1_data, a_rs2_data, a_tag, a_resp_ready,
        input  a_req_ready, a_resp_valid, a_resp_out, a_resp_tag, a_resp_illegal,
        output b_req_valid, b_func3, b_rs1_data, b_rs2_data, b_tag, b_resp_ready,
        input  b_req_ready, b_resp_valid, b_resp_taken, b_resp_tag, b_resp_illegal
    );

    modport slave (
        input  a_req_valid, a_func3, a_rs1_data, a_rs2_data, a_tag, a_resp_ready,
        output a_req_ready, a_resp_valid, a_resp_out, a_resp_tag, a_resp_illegal,
        input  b_req_valid, b_func3, b_rs1_data, b_rs2_data, b_tag, b_resp_ready,
        output b_req_ready, b_resp_valid, b_resp_taken, b_resp_tag, b_resp_illegal
    );
endinterface

// File: rtl/cmp_share_ctrl.sv
// Shared 32-bit comparator (eq / signed lt / unsigned lt) arbitrated between
// the ALU set-less-than path (A) and the branch unit (B). Each side owns a
// one-entry registered response buffer; FLUSH kills pending branch work.
module cmp_share_ctrl #(
    parameter int TAG_W      = 5,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_flush,
    cmp_share_if.slave bus
);
    // Response buffers and round-robin pointer (1 = B favoured on a tie)
    logic             r_a_vld, r_a_ill, r_b_vld, r_b_taken, r_b_ill, r_prio_b;
    logic [31:0]      r_a_out;
    logic [TAG_W-1:0] r_a_tag, r_b_tag;

    logic        w_a_elig, w_b_elig, w_gnt_a, w_gnt_b;
    logic [31:0] w_rs1, w_rs2;
    logic        w_eq, w_lts, w_ltu;
    logic [31:0] w_a_out;
    logic        w_a_ill, w_b_taken, w_b_ill;

    // Eligibility and single-grant arbitration; READY gated off during reset
    always_comb begin
        w_a_elig = i_rst_n & bus.a_req_valid & (~r_a_vld | bus.a_resp_ready);
        w_b_elig = i_rst_n & ~i_flush & bus.b_req_valid & (~r_b_vld | bus.b_resp_ready);
        w_gnt_b  = w_b_elig & (~w_a_elig | FIXED_PRIO | r_prio_b);
        w_gnt_a  = w_a_elig & ~w_gnt_b;
    end

    // The one shared comparator, fed from whichever side holds the grant
    always_comb begin
        w_rs1 = w_gnt_b ? bus.b_rs1_data : bus.a_rs1_data;
        w_rs2 = w_gnt_b ? bus.b_rs2_data : bus.a_rs2_data;
        w_eq  = (w_rs1 == w_rs2);
        w_lts = ($signed(w_rs1) < $signed(w_rs2));
        w_ltu = (w_rs1 < w_rs2);
    end

    // ALU result mapping: only SLT(010) and SLTU(011) are legal
    always_comb begin
        w_a_out = 32'd0;
        w_a_ill = 1'b0;
        case (bus.a_func3)
            3'b010:  w_a_out = {31'b0, w_lts};
            3'b011:  w_a_out = {31'b0, w_ltu};
            default: w_a_ill = 1'b1;
        endcase
    end

    // Branch decision mapping: 010/011 are not branch encodings
    always_comb begin
        w_b_taken = 1'b0;
        w_b_ill   = 1'b0;
        case (bus.b_func3)
            3'b000:  w_b_taken = w_eq;
            3'b001:  w_b_taken = ~w_eq;
            3'b100:  w_b_taken = w_lts;
            3'b101:  w_b_taken = ~w_lts;
            3'b110:  w_b_taken = w_ltu;
            3'b111:  w_b_taken = ~w_ltu;
            default: w_b_ill   = 1'b1;
        endcase
    end

    // Round-robin pointer moves only when somebody is actually granted
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     r_prio_b <= 1'b0;
        else if (w_gnt_a) r_prio_b <= 1'b1;
        else if (w_gnt_b) r_prio_b <= 1'b0;
    end

    // A buffer: refill on grant (wins over drain), else clear when consumed
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_vld <= 1'b0;
            r_a_out <= '0;
            r_a_tag <= '0;
            r_a_ill <= 1'b0;
        end else if (w_gnt_a) begin
            r_a_vld <= 1'b1;
            r_a_out <= w_a_out;
            r_a_tag <= bus.a_tag;
            r_a_ill <= w_a_ill;
        end else if (bus.a_resp_ready) begin
            r_a_vld <= 1'b0;
        end
    end

    // B buffer: flush kills any pending decision (no grant can coincide)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_b_vld   <= 1'b0;
            r_b_taken <= 1'b0;
            r_b_tag   <= '0;
            r_b_ill   <= 1'b0;
        end else if (i_flush) begin
            r_b_vld   <= 1'b0;
        end else if (w_gnt_b) begin
            r_b_vld   <= 1'b1;
            r_b_taken <= w_b_taken;
            r_b_tag   <= bus.b_tag;
            r_b_ill   <= w_b_ill;
        end else if (bus.b_resp_ready) begin
            r_b_vld   <= 1'b0;
        end
    end

    assign bus.a_req_ready    = w_gnt_a;
    assign bus.a_resp_valid   = r_a_vld;
    assign bus.a_resp_out     = r_a_out;
    assign bus.a_resp_tag     = r_a_tag;
    assign bus.a_resp_illegal = r_a_ill;
    assign bus.b_req_ready    = w_gnt_b;
    assign bus.b_resp_valid   = r_b_vld;
    assign bus.b_resp_taken   = r_b_taken;
    assign bus.b_resp_tag     = r_b_tag;
    assign bus.b_resp_illegal = r_b_ill;
endmodule

// File: tb/tb_cmp_share_ctrl.sv
// Directed bench for cmp_share_ctrl: the driver pushes hand-computed expected
// responses on each request handshake; a monitor pops and compares on each
// response handshake. A second instance checks strict branch priority.
module tb_cmp_share_ctrl;
    logic clk, rst_n, flush;

    cmp_share_if #(.TAG_W(5)) bus0 ();
    cmp_share_if #(.TAG_W(5)) bus1 ();

    cmp_share_ctrl #(.TAG_W(5), .FIXED_PRIO(1'b0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .bus(bus0.slave));
    cmp_share_ctrl #(.TAG_W(5), .FIXED_PRIO(1'b1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(1'b0), .bus(bus1.slave));

    typedef struct {
        logic [31:0] val;
        logic [4:0]  tag;
        logic        ill;
    } rsp_t;

    rsp_t qa[$];
    rsp_t qb[$];
    int n_chk = 0;
    int n_pass = 0;

    logic [31:0] exp_a_out;
    logic        exp_a_ill, exp_b_taken, exp_b_ill;
    logic        a_rdy_s, b_rdy_s;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Sample grants before the edge, queue expectations for the handshakes
    task automatic step();
        rsp_t e;
        @(negedge clk);
        a_rdy_s = bus0.a_req_ready;
        b_rdy_s = bus0.b_req_ready;
        if (bus0.a_req_valid && a_rdy_s) begin
            e.val = exp_a_out; e.tag = bus0.a_tag; e.ill = exp_a_ill;
            qa.push_back(e);
        end
        if (bus0.b_req_valid && b_rdy_s) begin
            e.val = {31'b0, exp_b_taken}; e.tag = bus0.b_tag; e.ill = exp_b_ill;
            qb.push_back(e);
        end
        cyc();
    endtask

    task automatic drv_a(input logic [2:0] f3, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [4:0] tg, input logic [31:0] ex, input logic il);
        bus0.a_req_valid = 1'b1; bus0.a_func3 = f3;
        bus0.a_rs1_data = r1; bus0.a_rs2_data = r2; bus0.a_tag = tg;
        exp_a_out = ex; exp_a_ill = il;
    endtask

    task automatic drv_b(input logic [2:0] f3, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [4:0] tg, input logic ex, input logic il);
        bus0.b_req_valid = 1'b1; bus0.b_func3 = f3;
        bus0.b_rs1_data = r1; bus0.b_rs2_data = r2; bus0.b_tag = tg;
        exp_b_taken = ex; exp_b_ill = il;
    endtask

    // Monitor: every consumed response must match the oldest expectation
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus0.a_resp_valid && bus0.a_resp_ready) begin
                    if (qa.size() == 0) begin
                        n_chk++;
                        $display("FAIL a_unexpected_resp actual tag=%0d expected none", bus0.a_resp_tag);
                    end else begin
                        e = qa.pop_front();
                        chk("a_resp_out", bus0.a_resp_out, e.val);
                        chk("a_resp_tag", 32'(bus0.a_resp_tag), 32'(e.tag));
                        chk("a_resp_ill", 32'(bus0.a_resp_illegal), 32'(e.ill));
                    end
                end
                if (bus0.b_resp_valid && bus0.b_resp_ready) begin
                    if (qb.size() == 0) begin
                        n_chk++;
                        $display("FAIL b_unexpected_resp actual tag=%0d expected none", bus0.b_resp_tag);
                    end else begin
                        e = qb.pop_front();
                        chk("b_resp_taken", 32'(bus0.b_resp_taken), e.val);
                        chk("b_resp_tag", 32'(bus0.b_resp_tag), 32'(e.tag));
                        chk("b_resp_ill", 32'(bus0.b_resp_illegal), 32'(e.ill));
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        bus0.a_req_valid = 1'b1; bus0.a_func3 = 3'b010; bus0.a_rs1_data = '0;
        bus0.a_rs2_data = '0; bus0.a_tag = '0; bus0.a_resp_ready = 1'b1;
        bus0.b_req_valid = 1'b1; bus0.b_func3 = 3'b000; bus0.b_rs1_data = '0;
        bus0.b_rs2_data = '0; bus0.b_tag = '0; bus0.b_resp_ready = 1'b1;
        bus1.a_req_valid = 1'b0; bus1.a_func3 = 3'b010; bus1.a_rs1_data = 32'd1;
        bus1.a_rs2_data = 32'd2; bus1.a_tag = 5'd1; bus1.a_resp_ready = 1'b1;
        bus1.b_req_valid = 1'b0; bus1.b_func3 = 3'b000; bus1.b_rs1_data = 32'd1;
        bus1.b_rs2_data = 32'd1; bus1.b_tag = 5'd2; bus1.b_resp_ready = 1'b1;
        exp_a_out = '0; exp_a_ill = 1'b0; exp_b_taken = 1'b0; exp_b_ill = 1'b0;

        // Reset state: no readies even with valid requests, buffers empty
        #3;
        chk("rst_a_req_ready", 32'(bus0.a_req_ready), 32'd0);
        chk("rst_b_req_ready", 32'(bus0.b_req_ready), 32'd0);
        chk("rst_a_resp_valid", 32'(bus0.a_resp_valid), 32'd0);
        chk("rst_b_resp_valid", 32'(bus0.b_resp_valid), 32'd0);
        chk("rst_a_resp_out", bus0.a_resp_out, 32'd0);
        chk("rst_b_resp_tag", 32'(bus0.b_resp_tag), 32'd0);
        bus0.a_req_valid = 1'b0; bus0.b_req_valid = 1'b0;
        #9 rst_n = 1'b1;
        cyc();

        // Round robin from reset: A,B,A,B
        for (int i = 0; i < 4; i++) begin
            drv_a(3'b010, 32'd3, 32'd5, 5'(i), 32'd1, 1'b0);
            drv_b(3'b000, 32'd3, 32'd3, 5'(16 + i), 1'b1, 1'b0);
            step();
            chk("rr_a_grant", 32'(a_rdy_s), 32'((i % 2) == 0));
            chk("rr_b_grant", 32'(b_rdy_s), 32'((i % 2) == 1));
        end
        bus0.a_req_valid = 1'b0; bus0.b_req_valid = 1'b0;
        step();

        // SLT / SLTU with -1 vs 1
        drv_a(3'b010, 32'hFFFF_FFFF, 32'd1, 5'd5, 32'd1, 1'b0);
        step();
        chk("slt_req_ready", 32'(a_rdy_s), 32'd1);
        chk("slt_resp_valid", 32'(bus0.a_resp_valid), 32'd1);
        drv_a(3'b011, 32'hFFFF_FFFF, 32'd1, 5'd5, 32'd0, 1'b0);
        step();
        chk("sltu_req_ready", 32'(a_rdy_s), 32'd1);
        // Illegal ALU func3
        drv_a(3'b000, 32'd5, 32'd5, 5'd7, 32'd0, 1'b1);
        step();
        bus0.a_req_valid = 1'b0;

        // Branch decisions, including illegal func3
        drv_b(3'b101, 32'h8000_0000, 32'd0, 5'd3, 1'b0, 1'b0); step();
        drv_b(3'b111, 32'h8000_0000, 32'd0, 5'd4, 1'b1, 1'b0); step();
        drv_b(3'b000, 32'd7, 32'd7, 5'd5, 1'b1, 1'b0);         step();
        drv_b(3'b011, 32'd1, 32'd2, 5'd6, 1'b0, 1'b1);         step();
        drv_b(3'b110, 32'hFFFF_FFFE, 32'd2, 5'd8, 1'b0, 1'b0); step();
        bus0.b_req_valid = 1'b0;
        step();

        // Backpressure on A: buffer holds, B still served, refill on release
        bus0.a_resp_ready = 1'b0;
        drv_a(3'b010, 32'd1, 32'd2, 5'd9, 32'd1, 1'b0);
        step();
        drv_a(3'b011, 32'd2, 32'd1, 5'd10, 32'd0, 1'b0);
        drv_b(3'b100, 32'd1, 32'd2, 5'd11, 1'b1, 1'b0);
        step();
        chk("stall_a_req_ready", 32'(a_rdy_s), 32'd0);
        chk("stall_b_req_ready", 32'(b_rdy_s), 32'd1);
        chk("stall_a_out", bus0.a_resp_out, 32'd1);
        chk("stall_a_tag", 32'(bus0.a_resp_tag), 32'd9);
        bus0.b_req_valid = 1'b0;
        step();
        chk("stall2_a_req_ready", 32'(a_rdy_s), 32'd0);
        chk("stall2_a_tag", 32'(bus0.a_resp_tag), 32'd9);
        bus0.a_resp_ready = 1'b1;
        step();
        chk("refill_a_req_ready", 32'(a_rdy_s), 32'd1);
        chk("refill_a_tag", 32'(bus0.a_resp_tag), 32'd10);
        chk("refill_a_out", bus0.a_resp_out, 32'd0);
        bus0.a_req_valid = 1'b0;
        step();

        // FLUSH with a pending branch decision and a new branch request
        bus0.b_resp_ready = 1'b0;
        drv_b(3'b000, 32'd1, 32'd1, 5'd12, 1'b1, 1'b0);
        step();
        drv_b(3'b001, 32'd1, 32'd2, 5'd13, 1'b1, 1'b0);
        drv_a(3'b011, 32'd1, 32'd2, 5'd14, 32'd1, 1'b0);
        flush = 1'b1;
        step();
        chk("flush_b_req_ready", 32'(b_rdy_s), 32'd0);
        chk("flush_a_req_ready", 32'(a_rdy_s), 32'd1);
        chk("flush_b_resp_valid", 32'(bus0.b_resp_valid), 32'd0);
        qb.delete();
        flush = 1'b0;
        bus0.b_req_valid = 1'b0; bus0.a_req_valid = 1'b0;
        bus0.b_resp_ready = 1'b1;
        step();
        chk("post_flush_b_resp_valid", 32'(bus0.b_resp_valid), 32'd0);

        // Strict branch priority starves A
        bus1.a_req_valid = 1'b1; bus1.b_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fixed_b_req_ready", 32'(bus1.b_req_ready), 32'd1);
            chk("fixed_a_req_ready", 32'(bus1.a_req_ready), 32'd0);
            cyc();
        end
        bus1.a_req_valid = 1'b0; bus1.b_req_valid = 1'b0;
        step();
        chk("qa_drained", 32'(qa.size()), 32'd0);
        chk("qb_drained", 32'(qb.size()), 32'd0);

        // Asynchronous reset while a response is held
        bus0.a_resp_ready = 1'b0;
        drv_a(3'b010, 32'd0, 32'd1, 5'd15, 32'd1, 1'b0);
        step();
        chk("pre_rst_a_resp_valid", 32'(bus0.a_resp_valid), 32'd1);
        bus0.a_req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_a_resp_valid", 32'(bus0.a_resp_valid), 32'd0);
        chk("async_rst_a_resp_tag", 32'(bus0.a_resp_tag), 32'd0);
        chk("async_rst_b_resp_valid", 32'(bus0.b_resp_valid), 32'd0);
        chk("async_rst_fixed_b_valid", 32'(bus1.b_resp_valid), 32'd0);
        qa.delete();
        #4 rst_n = 1'b1;
        cyc();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
